// File: rtl/output_limit_stage.sv
// Staging FWFT buffer between the upstream output FIFO and the high-speed I/O block; in limit
// mode it releases only the word count granted by the last accepted request. dout is combinational from the buffer head.
module output_limit_stage #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] up_dout,
  input  logic             up_empty,
  output logic             up_rd_en,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty,
  input  logic             mode_limit,
  input  logic             reg_output_limit,
  output logic [15:0]      output_limit,
  output logic             output_limit_not_done
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         OCC_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0]         CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {PASS, WAIT, RUN} state_t;

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [15:0]           output_limit_q, output_limit_d;
  logic                  not_done_q, not_done_d;
  logic                  rd_acc, wr_acc;

  // Buffer datapath; a full buffer still accepts a word when the head leaves on the same edge.
  always_comb begin
    empty    = (state_q == WAIT) || (occ_q == '0);
    rd_acc   = rd_en && !empty;
    wr_acc   = !RST && !up_empty && ((occ_q != OCC_FULL) || rd_acc);
    up_rd_en = wr_acc;
    dout     = mem[rd_ptr_q];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_acc && !rd_acc) occ_d = occ_q + CNT_ONE;
    else if (rd_acc && !wr_acc) occ_d = occ_q - CNT_ONE;
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    output_limit_d = output_limit_q;
    if (!mode_limit) begin
      state_d        = PASS;
      remaining_d    = '0;
      output_limit_d = '0;
    end else begin
      case (state_q)
        PASS: begin
          // Entering limit mode; a request in the same cycle is dropped.
          state_d     = WAIT;
          remaining_d = '0;
        end
        WAIT: begin
          if (reg_output_limit) begin
            output_limit_d = 16'(occ_q);
            remaining_d    = occ_q;
            state_d        = (occ_q != '0) ? RUN : WAIT;
          end
        end
        RUN: begin
          if (rd_acc) begin
            remaining_d = remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) state_d = WAIT;
          end
        end
        default: state_d = PASS;
      endcase
    end
    not_done_d = (remaining_d != '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= PASS;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
      remaining_q    <= '0;
      output_limit_q <= '0;
      not_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
      remaining_q    <= remaining_d;
      output_limit_q <= output_limit_d;
      not_done_q     <= not_done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr_q] <= up_dout;
  end

  assign output_limit          = output_limit_q;
  assign output_limit_not_done = not_done_q;

endmodule

// File: tb/tb_output_limit_stage.sv
// Directed bench for output_limit_stage: pass-through, limit grants, full buffer, ignored requests,
// simultaneous read/write and reset behaviour.
module tb_output_limit_stage;

  logic        CLK;
  logic        RST;
  logic [15:0] up_dout;
  logic        up_empty;
  logic        up_rd_en;
  logic [15:0] dout;
  logic        rd_en;
  logic        empty;
  logic        mode_limit;
  logic        reg_output_limit;
  logic [15:0] output_limit;
  logic        output_limit_not_done;

  output_limit_stage #(.WIDTH(16), .DEPTH_LOG2(5)) dut (
    .CLK(CLK), .RST(RST),
    .up_dout(up_dout), .up_empty(up_empty), .up_rd_en(up_rd_en),
    .dout(dout), .rd_en(rd_en), .empty(empty),
    .mode_limit(mode_limit), .reg_output_limit(reg_output_limit),
    .output_limit(output_limit), .output_limit_not_done(output_limit_not_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] src_q[$];
  logic [15:0] sb_q[$];
  logic [15:0] next_word = 16'h1000;
  int tests = 0;
  int fails = 0;
  int nread = 0;

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(next_word);
      next_word = next_word + 16'd1;
    end
  endtask

  // One clock of stimulus; every accepted read is compared against the words handed to the DUT.
  task automatic cycle(input logic mode, input logic rd, input logic pulse);
    logic wr, racc;
    logic [15:0] dsamp;
    @(negedge CLK);
    mode_limit       = mode;
    rd_en            = rd;
    reg_output_limit = pulse;
    up_empty         = (src_q.size() == 0);
    up_dout          = up_empty ? 16'hDEAD : src_q[0];
    #1;
    wr    = up_rd_en;
    racc  = rd && !empty;
    dsamp = dout;
    if (sb_q.size() == 32 && !racc) begin
      tests++;
      if (wr !== 1'b0) begin
        fails++;
        $display("FAIL overflow_write: up_rd_en=%b required 0 with 32 words held", wr);
      end
    end
    if (racc) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL read_underflow: read accepted dout=%h required no word available", dsamp);
      end else if (dsamp !== sb_q[0]) begin
        fails++;
        $display("FAIL data_order: dout=%h required %h", dsamp, sb_q[0]);
      end
    end
    @(posedge CLK);
    if (racc) begin
      nread++;
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    if (wr && src_q.size() > 0) sb_q.push_back(src_q.pop_front());
    #1;
    rd_en            = 1'b0;
    reg_output_limit = 1'b0;
    up_empty         = 1'b1;
  endtask

  task automatic test_reset();
    push_words(1);
    @(negedge CLK);
    up_empty = 1'b0;
    up_dout  = src_q[0];
    rd_en    = 1'b1;
    #1;
    tests += 4;
    if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b required 1", empty); end
    if (up_rd_en !== 1'b0) begin fails++; $display("FAIL rst_up_rd_en: got %b required 0", up_rd_en); end
    if (output_limit !== 16'd0) begin fails++; $display("FAIL rst_limit: got %0d required 0", output_limit); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL rst_not_done: got %b required 0", output_limit_not_done); end
    @(negedge CLK);
    up_empty = 1'b1;
    rd_en    = 1'b0;
    RST      = 1'b0;
    cycle(1'b0, 1'b1, 1'b0);
    tests += 2;
    if (empty !== 1'b0) begin fails++; $display("FAIL first_word_empty: got %b required 0", empty); end
    if (dout !== 16'h1000) begin fails++; $display("FAIL first_word_dout: got %h required 1000", dout); end
    cycle(1'b0, 1'b1, 1'b0);
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL first_word_drain: empty=%b required 1", empty); end
  endtask

  task automatic test_pass_through();
    int r0 = nread;
    push_words(40);
    for (int i = 0; i < 100 && (src_q.size() > 0 || sb_q.size() > 0); i++) cycle(1'b0, 1'b1, 1'b0);
    tests += 3;
    if (nread - r0 !== 40) begin fails++; $display("FAIL pass_count: got %0d required 40", nread - r0); end
    if (output_limit !== 16'd0) begin fails++; $display("FAIL pass_limit: got %0d required 0", output_limit); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL pass_not_done: got %b required 0", output_limit_not_done); end
  endtask

  task automatic test_limit_grant();
    int r0;
    cycle(1'b1, 1'b0, 1'b1);
    tests += 2;
    if (output_limit !== 16'd0) begin fails++; $display("FAIL enter_pulse_limit: got %0d required 0", output_limit); end
    if (empty !== 1'b1) begin fails++; $display("FAIL wait_empty: got %b required 1", empty); end
    r0 = nread;
    push_words(10);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    tests += 2;
    if (nread - r0 !== 0) begin fails++; $display("FAIL wait_reads: got %0d required 0", nread - r0); end
    if (empty !== 1'b1) begin fails++; $display("FAIL wait_preload_empty: got %b required 1", empty); end
    cycle(1'b1, 1'b0, 1'b1);
    tests += 3;
    if (output_limit !== 16'd10) begin fails++; $display("FAIL grant_limit: got %0d required 10", output_limit); end
    if (output_limit_not_done !== 1'b1) begin fails++; $display("FAIL grant_not_done: got %b required 1", output_limit_not_done); end
    if (empty !== 1'b0) begin fails++; $display("FAIL grant_empty: got %b required 0", empty); end
    r0 = nread;
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0);
    tests += 4;
    if (nread - r0 !== 10) begin fails++; $display("FAIL grant_count: got %0d required 10", nread - r0); end
    if (empty !== 1'b1) begin fails++; $display("FAIL grant_done_empty: got %b required 1", empty); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL grant_done_not_done: got %b required 0", output_limit_not_done); end
    if (output_limit !== 16'd10) begin fails++; $display("FAIL grant_hold_limit: got %0d required 10", output_limit); end
  endtask

  task automatic test_full_buffer();
    int r0;
    push_words(50);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0);
    tests++;
    if (src_q.size() !== 18) begin fails++; $display("FAIL full_accepted: left %0d required 18", src_q.size()); end
    @(negedge CLK);
    up_empty = 1'b0;
    up_dout  = src_q[0];
    #1;
    tests++;
    if (up_rd_en !== 1'b0) begin fails++; $display("FAIL full_up_rd_en: got %b required 0", up_rd_en); end
    up_empty = 1'b1;
    cycle(1'b1, 1'b0, 1'b1);
    tests++;
    if (output_limit !== 16'd32) begin fails++; $display("FAIL full_limit: got %0d required 32", output_limit); end
    r0 = nread;
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 1'b0);
    tests += 3;
    if (nread - r0 !== 32) begin fails++; $display("FAIL full_count: got %0d required 32", nread - r0); end
    if (src_q.size() !== 0) begin fails++; $display("FAIL full_refill: left %0d required 0", src_q.size()); end
    if (empty !== 1'b1) begin fails++; $display("FAIL full_done_empty: got %b required 1", empty); end
    cycle(1'b1, 1'b0, 1'b1);
    tests++;
    if (output_limit !== 16'd18) begin fails++; $display("FAIL refill_limit: got %0d required 18", output_limit); end
    r0 = nread;
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1, 1'b0);
    tests++;
    if (nread - r0 !== 18) begin fails++; $display("FAIL refill_count: got %0d required 18", nread - r0); end
  endtask

  task automatic test_ignored_pulses();
    int r0;
    cycle(1'b1, 1'b0, 1'b1);
    tests += 3;
    if (output_limit !== 16'd0) begin fails++; $display("FAIL zero_grant_limit: got %0d required 0", output_limit); end
    if (empty !== 1'b1) begin fails++; $display("FAIL zero_grant_empty: got %b required 1", empty); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL zero_grant_not_done: got %b required 0", output_limit_not_done); end
    push_words(8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    tests += 2;
    if (output_limit !== 16'd8) begin fails++; $display("FAIL run_pulse_limit: got %0d required 8", output_limit); end
    if (output_limit_not_done !== 1'b1) begin fails++; $display("FAIL run_pulse_not_done: got %b required 1", output_limit_not_done); end
    r0 = nread;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
    tests += 2;
    if (nread - r0 !== 5) begin fails++; $display("FAIL run_pulse_count: got %0d required 5", nread - r0); end
    if (empty !== 1'b1) begin fails++; $display("FAIL run_pulse_empty: got %b required 1", empty); end
  endtask

  task automatic test_simultaneous();
    int r0;
    push_words(3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0);
    push_words(1);
    cycle(1'b1, 1'b1, 1'b0);
    tests += 2;
    if (empty !== 1'b1) begin fails++; $display("FAIL simul_empty: got %b required 1", empty); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL simul_not_done: got %b required 0", output_limit_not_done); end
    cycle(1'b1, 1'b0, 1'b1);
    tests++;
    if (output_limit !== 16'd1) begin fails++; $display("FAIL simul_occ_limit: got %0d required 1", output_limit); end
    r0 = nread;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    tests++;
    if (nread - r0 !== 1) begin fails++; $display("FAIL simul_count: got %0d required 1", nread - r0); end
  endtask

  task automatic test_mode_exit();
    int r0;
    logic [15:0] w0;
    w0 = next_word;
    push_words(4);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    tests += 4;
    if (output_limit !== 16'd0) begin fails++; $display("FAIL exit_limit: got %0d required 0", output_limit); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL exit_not_done: got %b required 0", output_limit_not_done); end
    if (empty !== 1'b0) begin fails++; $display("FAIL exit_empty: got %b required 0", empty); end
    if (dout !== w0) begin fails++; $display("FAIL exit_dout: got %h required %h", dout, w0); end
    r0 = nread;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    tests++;
    if (nread - r0 !== 4) begin fails++; $display("FAIL exit_count: got %0d required 4", nread - r0); end
  endtask

  task automatic test_reset_mid_run();
    int r0;
    cycle(1'b1, 1'b0, 1'b0);
    push_words(9);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0);
    tests += 2;
    if (output_limit !== 16'd9) begin fails++; $display("FAIL midrun_limit: got %0d required 9", output_limit); end
    if (output_limit_not_done !== 1'b1) begin fails++; $display("FAIL midrun_not_done: got %b required 1", output_limit_not_done); end
    next_word = 16'hB000;
    push_words(3);
    @(negedge CLK);
    RST        = 1'b1;
    mode_limit = 1'b0;
    up_empty   = 1'b0;
    up_dout    = src_q[0];
    #1;
    tests += 4;
    if (empty !== 1'b1) begin fails++; $display("FAIL midrst_empty: got %b required 1", empty); end
    if (output_limit_not_done !== 1'b0) begin fails++; $display("FAIL midrst_not_done: got %b required 0", output_limit_not_done); end
    if (output_limit !== 16'd0) begin fails++; $display("FAIL midrst_limit: got %0d required 0", output_limit); end
    if (up_rd_en !== 1'b0) begin fails++; $display("FAIL midrst_up_rd_en: got %b required 0", up_rd_en); end
    @(negedge CLK);
    up_empty = 1'b1;
    RST      = 1'b0;
    sb_q.delete();
    r0 = nread;
    cycle(1'b0, 1'b1, 1'b0);
    tests++;
    if (dout !== 16'hB000) begin fails++; $display("FAIL midrst_first_dout: got %h required b000", dout); end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    tests++;
    if (nread - r0 !== 3) begin fails++; $display("FAIL midrst_count: got %0d required 3", nread - r0); end
  endtask

  initial begin
    RST              = 1'b1;
    mode_limit       = 1'b0;
    rd_en            = 1'b0;
    reg_output_limit = 1'b0;
    up_empty         = 1'b1;
    up_dout          = 16'h0000;
    test_reset();
    test_pass_through();
    test_limit_grant();
    test_full_buffer();
    test_ignored_pulses();
    test_simultaneous();
    test_mode_exit();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
